// File: rtl/gf_mul_fu.sv
// GF(2^M) multiply functional unit on a transport bus: operand register plus trigger,
// MSB-first shift-and-add multiply over M cycles, result read combinationally under r_re.
module gf_mul_fu #(
    parameter int             DAT_W = 16,
    parameter int             M     = 13,
    parameter logic [M-1:0]   POLY  = 13'h001B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DAT_W-1:0] bus_dat,
    input  logic             o_we,
    input  logic             t_we,
    input  logic             r_re,
    output logic [DAT_W-1:0] gfmul_r_dat,
    output logic             busy
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(M - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [M-1:0]     opnd_reg;
    logic [M-1:0]     a_reg;
    logic [M-1:0]     b_reg;
    logic [M-1:0]     acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [DAT_W-1:0] res_reg;

    logic [M-1:0]     acc_next;
    logic [M-1:0]     pp_sel;

    // Multiply by x, folding the overflowing x^M term back through the field polynomial.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        xtime = (v << 1) ^ (v[M-1] ? POLY : '0);
    endfunction

    // Partial product: working A gated by the current multiplier bit, one gate per bit.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_pp
            assign pp_sel[gi] = a_reg[gi] & b_reg[cnt_reg];
        end
    endgenerate

    always_comb begin
        acc_next = xtime(acc_reg) ^ pp_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            opnd_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            res_reg   <= '0;
        end else begin
            // Operand register is independent of the FSM; the running multiply uses its own copy.
            if (o_we) begin
                opnd_reg <= bus_dat[M-1:0];
            end

            case (state_reg)
                IDLE: begin
                    if (t_we) begin
                        a_reg     <= opnd_reg;
                        b_reg     <= bus_dat[M-1:0];
                        acc_reg   <= '0;
                        cnt_reg   <= CNT_TOP;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    if (cnt_reg == '0) begin
                        res_reg   <= DAT_W'(acc_next);
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == RUN);
    assign gfmul_r_dat = r_re ? res_reg : '0;

endmodule

// File: doc/gf_mul_fu.md
GF_MUL_FU -- requirements
Module: gf_mul_fu

Interface
REQ-001 SHALL have parameter DAT_W, default 16, bus/datapath width (bits).
REQ-002 SHALL have parameter M, default 13, field degree m of GF(2^m); M <= DAT_W.
REQ-003 SHALL have parameter POLY, default 13'h001B, low M bits of the field polynomial (x^13+x^4+x^3+x+1); x^M term implied.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bus_dat  input  DAT_W  transport bus value (output of the OR-combined bus).
REQ-007 SHALL have port o_we  input  1  load operand register from bus_dat.
REQ-008 SHALL have port t_we  input  1  load trigger from bus_dat and start a multiply.
REQ-009 SHALL have port r_re  input  1  drive result onto gfmul_r_dat this cycle.
REQ-010 SHALL have port gfmul_r_dat  output  DAT_W  result; all-zero when r_re=0.
REQ-011 SHALL have port busy  output  1  multiply in progress.

Function
REQ-012 SHALL compute R = A*B mod POLY in GF(2^M); A = operand register, B = trigger value; only bits [M-1:0] of bus_dat are used, bits [DAT_W-1:M] ignored.
REQ-013 SHALL use a two-state FSM: IDLE, RUN.
REQ-014 IDLE: t_we=1 SHALL copy operand register to working A, bus_dat[M-1:0] to working B, clear accumulator, set bit counter to M-1, go to RUN.
REQ-015 RUN: each cycle SHALL set acc = xtime(acc) XOR (B[cnt] ? A : 0), MSB-first; xtime = shift left 1, XOR POLY if bit M-1 was set.
REQ-016 RUN with cnt=0 SHALL load the result register with the new acc (zero-extended to DAT_W) and go to IDLE; otherwise cnt decrements.
REQ-017 Latency: trigger accepted at edge k SHALL give busy=1 for cycles k..k+M-1 (after edges k..k+M-1) and the new result readable from after edge k+M (M cycles).
REQ-018 busy SHALL be 1 exactly when FSM is RUN (registered, no combinational path from t_we).
REQ-019 t_we while RUN SHALL be ignored (no restart, no state change).
REQ-020 o_we SHALL update the operand register in either state; a running multiply SHALL be unaffected.
REQ-021 o_we and t_we in the same IDLE cycle: operand register SHALL take bus_dat; the started multiply SHALL use the operand value held before that edge.
REQ-022 gfmul_r_dat SHALL equal r_re ? result register : 0, combinational; r_re during RUN SHALL return the previous result.
REQ-023 Result register SHALL hold its value until the next completed multiply.

Reset
REQ-024 rst=1 SHALL asynchronously force FSM=IDLE, busy=0, and clear operand, working A/B, accumulator, counter, result to 0.
REQ-025 rst asserted mid-RUN SHALL abort the operation; the result register SHALL read 0 after reset, not a partial value.
REQ-026 After rst deasserts, the first t_we edge SHALL be accepted normally.

Verification
REQ-027 o_we with 0x0001, then t_we with 0x1234 -> busy for 13 cycles, then r_re gives 0x1234 & 0x1FFF = 0x1234.
REQ-028 o_we with 0x1000 (x^12), t_we with 0x0002 (x) -> result 0x001B.
REQ-029 o_we with 0x0ABC, t_we with 0x0000 -> result 0x0000; r_re=0 throughout -> gfmul_r_dat stays 0x0000.
REQ-030 t_we with 0x0003 issued 5 cycles into a RUN -> ignored; busy falls after 13 cycles total; result matches the first operation.
REQ-031 Same-cycle o_we/t_we in IDLE with bus 0x0002, prior operand 0x0005 -> result 0x000A; operand register then holds 0x0002.
REQ-032 rst pulse 6 cycles into RUN -> busy=0 immediately, result reads 0x0000; a fresh 0x0003*0x0003 trigger -> 0x0005.
